cpu_mul_sequencer: RTL and testbench
====================================

Name: cpu_mul_sequencer

Overview:
- Drives the CPU's 3-partial-product multiplier cell and folds the cell outputs into a final 32-bit result.
- The cell computes p1 = src1[15:0]*src2[15:0], p2 = src1[15:0]*src2[31:16] and p3 = src1[31:16]*src2[15:0], registered once when cell_en is high.
- The sequencer issues one pass to the cell for MUL (low word) and two passes for MULXUU, MULXSU and MULXSS (high word).
- It sits between the execute-stage request interface and the cell, with valid/ready handshakes on both request and response.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- HALF_W, 16, cell input slice width; must equal DATA_W/2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  operation: 0 MUL, 1 MULXUU, 2 MULXSU, 3 MULXSS.
- req_a  in  32  operand A (src1).
- req_b  in  32  operand B (src2).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  32  result word.
- cell_src1  out  32  to cell E_src1.
- cell_src2  out  32  to cell E_src2.
- cell_en  out  1  to cell M_en.
- cell_p1  in  32  cell lo*lo product.
- cell_p2  in  32  cell lo(a)*hi(b) product.
- cell_p3  in  32  cell hi(a)*lo(b) product.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - rsp_valid = 0, rsp_result = 0, cell_en = 0, cell_src1/2 = 0.
  - All internal partial registers are cleared; req_ready = 1 in the following cycle.
- States: IDLE, P1, P2, FIN, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch a, b and op, then go to P1.
  - req_ready is 0 in every other state; one operation is in flight at a time.
- P1:
  - cell_src1 = a, cell_src2 = b, cell_en = 1.
  - Next state: FIN if op = MUL, else P2.
- P2:
  - Capture ll = cell_p1, lh = cell_p2, hl = cell_p3 (pass-1 results).
  - Drive cell_src1 = {16'h0, a[31:16]}, cell_src2 = {16'h0, b[31:16]}, cell_en = 1.
  - Next state: FIN.
- FIN (cell_en = 0, cell outputs hold):
  - MUL: rsp_result <= (cell_p1 + ((cell_p2 + cell_p3) << 16)) mod 2^32.
  - Other ops: hh = cell_p1.
    - uu[63:0] = {hh, 32'h0} + ({31'h0, lh + hl (33-bit)} << 16) + {32'h0, ll}.
    - hi = uu[63:32].
    - MULXUU: hi.
    - MULXSU: hi - (a[31] ? b : 0).
    - MULXSS: hi - (a[31] ? b : 0) - (b[31] ? a : 0).
    - All subtractions are mod 2^32.
  - Next state: RESP.
- RESP:
  - rsp_valid = 1; rsp_result is held stable.
  - On rsp_ready, go to IDLE and deassert rsp_valid next cycle.
  - A new request cannot be accepted in the same cycle as the response; the minimum issue interval is 4 cycles (MUL) or 5 cycles (others).
- Latency: accept edge to rsp_valid high is 3 cycles (MUL) or 4 cycles (others).
- cell_en outputs: exactly one pulse per MUL and two pulses per other op; cell_src1/2 = 0 outside P1/P2.
- Reset in any state aborts the operation; no response is produced and no further cell_en pulse is issued.
- req_valid held during reset is ignored until reset deasserts.
- The cell uses its own async clear; the top level ties it to ~reset. The sequencer must not rely on cell contents after reset.

Decomposition:
- Package cpu_mul_pkg:
  - op encoding (MUL, MULXUU, MULXSU, MULXSS).
  - state enum.
  - HALF_W constant.
- Sub-module cpu_mul_fold: purely combinational.
  - Inputs: ll/lh/hl/hh, a, b, op.
  - Output: 32-bit result.
  - Reused by the formal model.

Test Plan:
- MUL, a = 0x12345678, b = 0x00000010 -> rsp_result 0x23456780; rsp_valid exactly 3 cycles after accept; one cell_en pulse.
- MULXUU, a = b = 0xFFFFFFFF -> 0xFFFFFFFE; two cell_en pulses; second pulse carries src1 = src2 = 0x0000FFFF.
- MULXSS, a = b = 0xFFFFFFFF -> 0x00000000; MULXSS, a = 0x80000000, b = 0x80000000 -> 0x40000000.
- MULXSU, a = 0xFFFFFFFF, b = 0x00000002 -> 0xFFFFFFFF; MULXSU, a = 0x00000002, b = 0xFFFFFFFF -> 0x00000001.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid.
  - rsp_result stays stable, req_ready stays 0, cell_en stays 0.
  - Then rsp_ready = 1 with a back-to-back request pending: accepted the cycle after the handshake.
- Assert reset during P2 of a MULXSS:
  - Next cycle: state IDLE, rsp_valid = 0, req_ready = 1, cell_en = 0.
  - A subsequent MUL, 3 * 5, returns 15 with no stale data.

Source files
------------

// File: rtl/cpu_mul_pkg.sv
// cpu_mul_pkg: shared widths, op encoding and sequencer states for the multiply sequencer
package cpu_mul_pkg;
  localparam int DATA_W = 32;
  localparam int HALF_W = DATA_W / 2;
  typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS} op_e;
  typedef enum logic [2:0] {IDLE, P1, P2, FIN, RESP} state_e;
endpackage

// File: rtl/cpu_mul_sequencer_if.sv
// cpu_mul_sequencer_if: execute-stage request/response handshake bundle
interface cpu_mul_sequencer_if;
  import cpu_mul_pkg::*;
  logic req_valid;
  logic req_ready;
  op_e req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  modport master(output req_valid, req_op, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_result);
  modport slave(input req_valid, req_op, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_result);
endinterface

// File: rtl/cpu_mul_fold.sv
// cpu_mul_fold: combines the 16x16 partial products into the low or signed/unsigned high result word
module cpu_mul_fold
  import cpu_mul_pkg::*;
(
  input  logic [DATA_W-1:0] ll,
  input  logic [DATA_W-1:0] lh,
  input  logic [DATA_W-1:0] hl,
  input  logic [DATA_W-1:0] hh,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W:0] mid;
  logic [2*DATA_W-1:0] uu;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] fix_a;
  logic [DATA_W-1:0] fix_b;
  // full unsigned 64-bit product, then signed corrections on the high word
  always_comb begin
    mid = {1'b0, lh} + {1'b0, hl};
    uu = {hh, {DATA_W{1'b0}}} + ({{(DATA_W-1){1'b0}}, mid} << HALF_W) + {{DATA_W{1'b0}}, ll};
    hi = uu[2*DATA_W-1:DATA_W];
    fix_a = a[DATA_W-1] ? b : '0;
    fix_b = b[DATA_W-1] ? a : '0;
    result = op == OP_MUL ? uu[DATA_W-1:0] :
             op == OP_MULXUU ? hi :
             op == OP_MULXSU ? hi - fix_a : hi - fix_a - fix_b;
  end
endmodule

// File: rtl/cpu_mul_sequencer.sv
// cpu_mul_sequencer: drives the 3-partial-product multiplier cell in one or two passes and folds the result
module cpu_mul_sequencer
  import cpu_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  cpu_mul_sequencer_if.slave bus,
  output logic [DATA_W-1:0] cell_src1,
  output logic [DATA_W-1:0] cell_src2,
  output logic              cell_en,
  input  logic [DATA_W-1:0] cell_p1,
  input  logic [DATA_W-1:0] cell_p2,
  input  logic [DATA_W-1:0] cell_p3
);
  state_e state, state_nx;
  op_e op;
  logic [DATA_W-1:0] a, b, ll, lh, hl, result, fold_res;
  logic is_mul;
  assign is_mul = op == OP_MUL;
  assign bus.req_ready = state == IDLE && !reset;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_result = result;
  // MUL folds straight from the cell; high-word ops use pass-1 registers plus the pass-2 hh product
  cpu_mul_fold u_fold (
    .ll(is_mul ? cell_p1 : ll),
    .lh(is_mul ? cell_p2 : lh),
    .hl(is_mul ? cell_p3 : hl),
    .hh(cell_p1),
    .a(a),
    .b(b),
    .op(op),
    .result(fold_res)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state and cell drive; cell inputs idle at zero outside the two passes
  always_comb begin
    state_nx = state;
    cell_en = 1'b0;
    cell_src1 = '0;
    cell_src2 = '0;
    case (state)
      IDLE: state_nx = bus.req_valid ? P1 : IDLE;
      P1: begin
        cell_en = 1'b1;
        cell_src1 = a;
        cell_src2 = b;
        state_nx = is_mul ? FIN : P2;
      end
      P2: begin
        cell_en = 1'b1;
        cell_src1 = {{HALF_W{1'b0}}, a[DATA_W-1:HALF_W]};
        cell_src2 = {{HALF_W{1'b0}}, b[DATA_W-1:HALF_W]};
        state_nx = FIN;
      end
      FIN: state_nx = RESP;
      RESP: state_nx = bus.rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // operand latch, pass-1 partial capture and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= OP_MUL;
      a <= '0;
      b <= '0;
      ll <= '0;
      lh <= '0;
      hl <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        op <= bus.req_op;
        a <= bus.req_a;
        b <= bus.req_b;
      end
      if (state == P2) begin
        ll <= cell_p1;
        lh <= cell_p2;
        hl <= cell_p3;
      end
      if (state == FIN) result <= fold_res;
    end
  end
endmodule

// File: tb/tb_cpu_mul_sequencer.sv
// tb_cpu_mul_sequencer: directed vectors against a transaction-level timing/arithmetic model
module tb_cpu_mul_sequencer;
  import cpu_mul_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;
  logic cell_en;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit busy = 0;
  int k = 0;
  int lat = 0;
  logic [31:0] ma = 0, mb = 0, mexp = 0;
  cpu_mul_sequencer_if bus();
  cpu_mul_sequencer dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .cell_src1(cell_src1),
    .cell_src2(cell_src2),
    .cell_en(cell_en),
    .cell_p1(cell_p1),
    .cell_p2(cell_p2),
    .cell_p3(cell_p3)
  );
  always #5 clk = ~clk;
  // multiplier cell: one registered stage, async clear tied to ~reset
  always @(posedge clk or posedge reset)
    if (reset) begin
      cell_p1 <= 0;
      cell_p2 <= 0;
      cell_p3 <= 0;
    end else if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  function automatic logic [31:0] ref_fn(input op_e o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx, yy, p;
    xx = (o == OP_MULXSU || o == OP_MULXSS) ? {{32{x[31]}}, x} : {32'h0, x};
    yy = (o == OP_MULXSS) ? {{32{y[31]}}, y} : {32'h0, y};
    p = xx * yy;
    return o == OP_MUL ? p[31:0] : p[63:32];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: k counts cycles since the accept cycle of the transaction in flight
  always @(posedge clk) begin
    if (reset) busy = 0;
    else if (busy) begin
      if (k >= lat && bus.rsp_ready) busy = 0;
      else k++;
    end else if (bus.req_valid) begin
      busy = 1;
      k = 1;
      lat = bus.req_op == OP_MUL ? 3 : 4;
      ma = bus.req_a;
      mb = bus.req_b;
      mexp = ref_fn(bus.req_op, bus.req_a, bus.req_b);
    end
  end
  // per-cycle compare of every DUT output against the model
  always @(negedge clk) if (!reset) begin
    bit een, pass2;
    logic [31:0] es1, es2;
    pass2 = busy && k == 2 && lat == 4;
    een = busy && k == 1 || pass2;
    es1 = !een ? 32'h0 : pass2 ? {16'h0, ma[31:16]} : ma;
    es2 = !een ? 32'h0 : pass2 ? {16'h0, mb[31:16]} : mb;
    if (cell_en) pulses++;
    chk("req_ready", 32'(bus.req_ready), 32'(!busy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(busy && k >= lat));
    chk("cell_en", 32'(cell_en), 32'(een));
    chk("cell_src1", cell_src1, es1);
    chk("cell_src2", cell_src2, es2);
    if (busy && k >= lat) chk("rsp_result", bus.rsp_result, mexp);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input op_e o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] lit, input int stall);
    int n;
    bit got;
    pulses = 0;
    bus.req_op = o;
    bus.req_a = x;
    bus.req_b = y;
    bus.req_valid = 1;
    n = 0;
    do begin
      got = bus.req_ready;
      step();
      n++;
    end while (!got && n < 20);
    bus.req_valid = 0;
    chk("accept_wait", n, 1);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, o == OP_MUL ? 3 : 4);
    chk("result_lit", bus.rsp_result, lit);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_result", bus.rsp_result, lit);
      chk("stall_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
    chk("cell_pulses", pulses, o == OP_MUL ? 1 : 2);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req_valid = 0;
    bus.req_op = OP_MUL;
    bus.req_a = 0;
    bus.req_b = 0;
    bus.rsp_ready = 0;
    repeat (3) step();
    reset = 0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_cell_en", 32'(cell_en), 0);
    chk("rst_cell_src1", cell_src1, 0);
    step();
    run_op(OP_MUL, 32'h12345678, 32'h00000010, 32'h23456780, 0);
    run_op(OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op(OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
    run_op(OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op(OP_MULXSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0);
    run_op(OP_MULXSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 5);
    run_op(OP_MUL, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0);
    run_op(OP_MULXUU, 32'h89ABCDEF, 32'h12345678, 32'h09CA39E0, 3);
    bus.req_op = OP_MULXSS;
    bus.req_a = 32'hDEADBEEF;
    bus.req_b = 32'hCAFEF00D;
    bus.req_valid = 1;
    step();
    bus.req_valid = 0;
    step();
    reset = 1;
    bus.req_op = OP_MUL;
    bus.req_a = 3;
    bus.req_b = 5;
    bus.req_valid = 1;
    step();
    reset = 0;
    #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_req_ready", 32'(bus.req_ready), 1);
    chk("abort_cell_en", 32'(cell_en), 0);
    run_op(OP_MUL, 3, 5, 15, 0);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
